// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl - job sequencer for the serial deterministic stochastic-computing
// multiplier (N-input, W-bit SNG cascade followed by a stoch-to-binary counter).
//
// Accepts one job at a time and latches its operands. It then clears the
// datapath for one cycle and enables it for up to 2^(N*W) stream cycles. It
// captures the product count and holds it until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The source may hold valid high at any time. in_valid is only looked at
// while in_ready is high (IDLE). out_ready is only looked at while out_valid is
// high (DONE). The controller never drops out_valid, out_z or out_cycles before
// the transfer.
//
// Optional feature: define DSC_EARLY_STOP_EN to end RUN on the first qualified
// mul_ov (any RUN cycle except the first). Without it mul_ov is ignored.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_ready, in_a..in_d    job input handshake and operands
//   out_valid / out_ready, out_z       result handshake and captured product count
//   out_cycles                         RUN cycles spent on the job
//   busy                               state != IDLE
//   mul_a..mul_d, mul_rst, mul_en      drive the multiplier instance
//   mul_z, mul_ov                      multiplier count and termination flag
//   dbg_state                          current FSM state (debug observation)
module dsc_mul_ctrl #(
  parameter int SNG_WIDTH  = 6,
  parameter int NUM_INPUTS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SNG_WIDTH-1:0]              in_a,
  input  logic [SNG_WIDTH-1:0]              in_b,
  input  logic [SNG_WIDTH-1:0]              in_c,
  input  logic [SNG_WIDTH-1:0]              in_d,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]   out_z,
  output logic [NUM_INPUTS*SNG_WIDTH:0]     out_cycles,
  output logic                              busy,
  output logic [SNG_WIDTH-1:0]              mul_a,
  output logic [SNG_WIDTH-1:0]              mul_b,
  output logic [SNG_WIDTH-1:0]              mul_c,
  output logic [SNG_WIDTH-1:0]              mul_d,
  output logic                              mul_rst,
  output logic                              mul_en,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]   mul_z,
  input  logic                              mul_ov,
  output logic [2:0]                        dbg_state
);

  localparam int ZW = NUM_INPUTS * SNG_WIDTH;
  localparam int CW = ZW + 1;
  localparam logic [CW-1:0] FULL_COUNT = {1'b1, {ZW{1'b0}}};

`ifdef DSC_EARLY_STOP_EN
  localparam logic EARLY_STOP = 1'b1;
`else
  localparam logic EARLY_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SNG_WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [ZW-1:0]          z_q, z_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic                   mul_rst_q, mul_rst_d;
  logic                   mul_en_q, mul_en_d;

  // Operands beyond NUM_INPUTS are neutral (all-ones) so they never zero a job.
  logic [SNG_WIDTH-1:0]   a_eff, b_eff, c_eff, d_eff;
  logic                   any_zero;
  logic [CW-1:0]          cyc_inc;
  logic                   ov_stop;

  always_comb begin
    a_eff    = (NUM_INPUTS > 0) ? in_a : '1;
    b_eff    = (NUM_INPUTS > 1) ? in_b : '1;
    c_eff    = (NUM_INPUTS > 2) ? in_c : '1;
    d_eff    = (NUM_INPUTS > 3) ? in_d : '1;
    any_zero = (a_eff == '0) || (b_eff == '0) || (c_eff == '0) || (d_eff == '0);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    z_d     = z_q;
    cyc_d   = cyc_q;
    cyc_inc = (cyc_q == FULL_COUNT) ? cyc_q : cyc_q + 1'b1;
    // The first RUN cycle (cyc_q == 0) is skipped: the datapath is still
    // settling from the clear and its flag is meaningless there.
    ov_stop = EARLY_STOP & mul_ov & (cyc_q != '0);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_eff;
          b_d     = b_eff;
          c_d     = c_eff;
          d_d     = d_eff;
          z_d     = '0;
          cyc_d   = '0;
          state_d = any_zero ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        cyc_d = cyc_inc;
        if ((cyc_inc == FULL_COUNT) || ov_stop) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Enable dropped at the end of RUN, so the final count is stable here.
        z_d     = mul_z;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Datapath controls are registered from the next state so they line up
    // exactly with the CLEAR and RUN cycles.
    mul_rst_d = (state_d == S_CLEAR);
    mul_en_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      z_q       <= '0;
      cyc_q     <= '0;
      mul_rst_q <= 1'b1;
      mul_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      z_q       <= z_d;
      cyc_q     <= cyc_d;
      mul_rst_q <= mul_rst_d;
      mul_en_q  <= mul_en_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_z      = z_q;
  assign out_cycles = cyc_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_c      = c_q;
  assign mul_d      = d_q;
  assign mul_rst    = mul_rst_q;
  assign mul_en     = mul_en_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
module tb_dsc_mul_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- main DUT: W=2, N=2 (full period 16) ----------------
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [1:0] mul_a, mul_b, mul_c, mul_d;
  logic [3:0] out_z, mul_z;
  logic [4:0] out_cycles;
  logic       mul_rst, mul_en, mul_ov;
  logic [2:0] dbg_state;

  dsc_mul_ctrl #(.SNG_WIDTH(2), .NUM_INPUTS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT: default W=6, N=4, zero-operand only ----------------
  logic        z_in_valid = 1'b0, z_in_ready, z_out_valid, z_busy, z_mul_rst, z_mul_en;
  logic [5:0]  z_in_a = '0, z_in_b = '0, z_in_c = '0, z_in_d = '0;
  logic [5:0]  z_mul_a, z_mul_b, z_mul_c, z_mul_d;
  logic [23:0] z_out_z;
  logic [24:0] z_out_cycles;
  logic [2:0]  z_dbg_state;

  dsc_mul_ctrl dut_z (
    .clk(clk), .rst(rst),
    .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_a(z_in_a), .in_b(z_in_b), .in_c(z_in_c), .in_d(z_in_d),
    .out_valid(z_out_valid), .out_ready(1'b0),
    .out_z(z_out_z), .out_cycles(z_out_cycles), .busy(z_busy),
    .mul_a(z_mul_a), .mul_b(z_mul_b), .mul_c(z_mul_c), .mul_d(z_mul_d),
    .mul_rst(z_mul_rst), .mul_en(z_mul_en), .mul_z(24'd0), .mul_ov(1'b0),
    .dbg_state(z_dbg_state)
  );

  // ---------------- behavioural deterministic SC datapath ----------------
  // Stream index k: a's stream uses k[1:0] (fast), b's uses k[3:2] (slow), so a
  // full period of 16 counts exactly a*b coincident ones.
  logic [3:0] dp_k = '0, dp_z = '0;
  int         ov_mode = 0;  // 0 none, 1 ov from RUN cycle 5 on, 2 ov only in RUN cycle 1
  always @(posedge clk) begin
    if (mul_rst) begin
      dp_k <= '0;
      dp_z <= '0;
    end else if (mul_en) begin
      dp_k <= dp_k + 4'd1;
      if ((dp_k[1:0] < mul_a) && (dp_k[3:2] < mul_b)) dp_z <= dp_z + 4'd1;
    end
  end
  assign mul_z  = dp_z;
  assign mul_ov = mul_en && (((ov_mode == 1) && (dp_k >= 4'd4)) || ((ov_mode == 2) && (dp_k == 4'd0)));

  // Cycle counters for datapath control pulses, sampled mid-cycle.
  int en_cnt = 0, rst_cnt = 0, z_en_cnt = 0, z_rst_cnt = 0;
  always @(negedge clk) begin
    if (mul_en) en_cnt++;
    if (mul_rst && rst) rst_cnt++;
    if (z_mul_en) z_en_cnt++;
    if (z_mul_rst && rst) z_rst_cnt++;
  end

`ifdef DSC_EARLY_STOP_EN
  localparam int EXP_ES_R = 5;
  localparam int EXP_ES_Z = 4;
`else
  localparam int EXP_ES_R = 16;
  localparam int EXP_ES_Z = 6;
`endif

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] c, input logic [1:0] d);
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accept until out_valid; 200 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
  endtask

  task automatic finish_job();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_busy_valid got=%0b%0b exp=00", busy, out_valid); end
    checks++; if (mul_rst !== 1'b1 || mul_en !== 1'b0) begin failures++; $display("FAIL reset_mul_ctrl got rst=%0b en=%0b exp rst=1 en=0", mul_rst, mul_en); end
    checks++; if (out_z !== 4'd0 || out_cycles !== 5'd0 || mul_a !== 2'd0) begin failures++; $display("FAIL reset_data got z=%0d cyc=%0d a=%0d exp 0", out_z, out_cycles, mul_a); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (mul_rst !== 1'b0) begin failures++; $display("FAIL reset_release_mul_rst got=%0b exp=0", mul_rst); end
  endtask

  task automatic test_full_run();
    int lat;
    en_cnt = 0; rst_cnt = 0; ov_mode = 0;
    start_job(2'd3, 2'd2, 2'd0, 2'd0);  // c,d unused with N=2: their zero must not matter
    wait_done(lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL full_latency got=%0d exp=18", lat); end
    checks++; if (en_cnt !== 16) begin failures++; $display("FAIL full_en_cycles got=%0d exp=16", en_cnt); end
    checks++; if (rst_cnt !== 1) begin failures++; $display("FAIL full_rst_pulse got=%0d exp=1", rst_cnt); end
    checks++; if (out_cycles !== 5'd16) begin failures++; $display("FAIL full_out_cycles got=%0d exp=16", out_cycles); end
    checks++; if (out_z !== 4'd6) begin failures++; $display("FAIL full_out_z got=%0d exp=6", out_z); end
    checks++; if (mul_a !== 2'd3 || mul_b !== 2'd2) begin failures++; $display("FAIL full_mul_ops got a=%0d b=%0d exp a=3 b=2", mul_a, mul_b); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL full_done_flags got busy=%0b rdy=%0b exp busy=1 rdy=0", busy, in_ready); end
    finish_job();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL full_release got rdy=%0b vld=%0b exp rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_zero_operand();
    int lat;
    // Small instance: previous job left out_z=6, so a zero result is meaningful.
    en_cnt = 0; rst_cnt = 0;
    start_job(2'd2, 2'd0, 2'd1, 2'd1);
    wait_done(lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (out_z !== 4'd0 || out_cycles !== 5'd0) begin failures++; $display("FAIL zero_result got z=%0d cyc=%0d exp 0 0", out_z, out_cycles); end
    checks++; if (en_cnt !== 0 || rst_cnt !== 0) begin failures++; $display("FAIL zero_no_datapath got en=%0d rst=%0d exp 0 0", en_cnt, rst_cnt); end
    finish_job();

    // Default-size instance, a=0 b=5 c=7 d=1.
    z_en_cnt = 0; z_rst_cnt = 0;
    @(negedge clk);
    z_in_a = 6'd0; z_in_b = 6'd5; z_in_c = 6'd7; z_in_d = 6'd1;
    z_in_valid = 1'b1;
    @(posedge clk);
    #1 z_in_valid = 1'b0;
    checks++; if (z_out_valid !== 1'b1) begin failures++; $display("FAIL zero_w6_latency got vld=%0b exp=1", z_out_valid); end
    checks++; if (z_out_z !== 24'd0 || z_out_cycles !== 25'd0) begin failures++; $display("FAIL zero_w6_result got z=%0d cyc=%0d exp 0 0", z_out_z, z_out_cycles); end
    checks++; if (z_mul_b !== 6'd5 || z_mul_c !== 6'd7) begin failures++; $display("FAIL zero_w6_latch got b=%0d c=%0d exp 5 7", z_mul_b, z_mul_c); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (z_en_cnt !== 0 || z_rst_cnt !== 0 || z_out_valid !== 1'b1) begin failures++; $display("FAIL zero_w6_hold got en=%0d rst=%0d vld=%0b exp 0 0 1", z_en_cnt, z_rst_cnt, z_out_valid); end
  endtask

  task automatic test_early_stop();
    int lat;
    en_cnt = 0; ov_mode = 1;
    start_job(2'd3, 2'd2, 2'd1, 2'd1);
    wait_done(lat);
    checks++; if (lat !== EXP_ES_R + 2) begin failures++; $display("FAIL es_latency got=%0d exp=%0d", lat, EXP_ES_R + 2); end
    checks++; if (en_cnt !== EXP_ES_R) begin failures++; $display("FAIL es_en_cycles got=%0d exp=%0d", en_cnt, EXP_ES_R); end
    checks++; if (out_cycles !== 5'(EXP_ES_R)) begin failures++; $display("FAIL es_out_cycles got=%0d exp=%0d", out_cycles, EXP_ES_R); end
    checks++; if (out_z !== 4'(EXP_ES_Z)) begin failures++; $display("FAIL es_out_z got=%0d exp=%0d", out_z, EXP_ES_Z); end
    finish_job();

    // ov only in the first RUN cycle is never qualified.
    en_cnt = 0; ov_mode = 2;
    start_job(2'd3, 2'd2, 2'd1, 2'd1);
    wait_done(lat);
    checks++; if (lat !== 18 || en_cnt !== 16) begin failures++; $display("FAIL es_first_cycle_ignored got lat=%0d en=%0d exp 18 16", lat, en_cnt); end
    checks++; if (out_cycles !== 5'd16 || out_z !== 4'd6) begin failures++; $display("FAIL es_first_cycle_result got cyc=%0d z=%0d exp 16 6", out_cycles, out_z); end
    ov_mode = 0;
  endtask

  task automatic test_back_to_back();
    int lat;
    // Enter with the previous job's result (cyc=16, z=6, a=3, b=2) in DONE.
    en_cnt = 0;
    @(negedge clk);
    in_a = 2'd1; in_b = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_z !== 4'd6 || out_cycles !== 5'd16 || in_ready !== 1'b0 || mul_a !== 2'd3) begin
        failures++;
        $display("FAIL backpressure_hold cyc%0d got vld=%0b z=%0d cyc=%0d rdy=%0b a=%0d exp 1 6 16 0 3",
                 i, out_valid, out_z, out_cycles, in_ready, mul_a);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || mul_a !== 2'd3) begin failures++; $display("FAIL b2b_idle got rdy=%0b a=%0d exp 1 3", in_ready, mul_a); end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (dbg_state !== 3'd1 || mul_a !== 2'd1 || mul_b !== 2'd1) begin failures++; $display("FAIL b2b_accept got st=%0d a=%0d b=%0d exp 1 1 1", dbg_state, mul_a, mul_b); end
    wait_done(lat);
    checks++; if (lat !== 18 || en_cnt !== 16) begin failures++; $display("FAIL b2b_second_run got lat=%0d en=%0d exp 18 16", lat, en_cnt); end
    checks++; if (out_z !== 4'd1 || out_cycles !== 5'd16) begin failures++; $display("FAIL b2b_second_result got z=%0d cyc=%0d exp 1 16", out_z, out_cycles); end
    finish_job();
  endtask

  task automatic test_reset_mid_run();
    int snap;
    start_job(2'd3, 2'd2, 2'd1, 2'd1);
    repeat (7) @(posedge clk);  // CLEAR, then into RUN cycle 7
    #1;
    checks++; if (mul_en !== 1'b1 || dp_k !== 4'd6) begin failures++; $display("FAIL midrun_pre got en=%0b k=%0d exp 1 6", mul_en, dp_k); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mul_en !== 1'b0 || mul_rst !== 1'b1 ||
        out_z !== 4'd0 || out_cycles !== 5'd0 || mul_a !== 2'd0 || mul_b !== 2'd0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL midrun_async got rdy=%0b busy=%0b vld=%0b en=%0b mrst=%0b z=%0d cyc=%0d a=%0d b=%0d st=%0d exp 1 0 0 0 1 0 0 0 0 0",
               in_ready, busy, out_valid, mul_en, mul_rst, out_z, out_cycles, mul_a, mul_b, dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    snap = en_cnt;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || mul_en !== 1'b0 || mul_rst !== 1'b0 || en_cnt !== snap) begin failures++; $display("FAIL midrun_after got rdy=%0b en=%0b mrst=%0b encnt=%0d exp 1 0 0 %0d", in_ready, mul_en, mul_rst, en_cnt, snap); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_run();
    test_zero_operand();
    test_early_stop();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
